sccb_write_arbiter: RTL and testbench

Arbitrates shared access to the single SCCB write engine (`I2C_interface`, camera slave 0x42) between two register-write requesters. Port 0 is the power-up configuration sequencer and port 1 is the runtime tuning logic (exposure/gain/AWB writes). The block latches the granted request and drives the engine's write-enable for exactly one transaction. It returns a per-port acknowledge. After a sensor soft-reset write (COM7 bit 7), it enforces a settle delay and flags stalled transactions by timeout.

---
 rtl/sccb_pkg.sv | 22 ++
 rtl/sccb_write_arbiter.sv | 136 +++++++++++++
 tb/tb_sccb_write_arbiter.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sccb_pkg.sv
// Shared SCCB definitions: arbiter state encoding, the soft-reset register bit
// and the camera slave ID used by the configuration sequencer.
package sccb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_SETTLE = 2'd2
    } sccb_state_e;

    localparam int          SOFT_RESET_BIT = 7;
    localparam logic [7:0]  SCCB_SLAVE_ID  = 8'h42;
    localparam int          CNT_W          = 20;

    // A write triggers the sensor soft reset when it hits the trigger address with bit 7 set.
    function automatic logic is_soft_reset_write(input logic [7:0] addr,
                                                 input logic [7:0] data,
                                                 input logic [7:0] trig_addr);
        return (addr == trig_addr) && data[SOFT_RESET_BIT];
    endfunction

endpackage

// File: rtl/sccb_write_arbiter.sv
// Round-robin arbiter in front of the single SCCB write engine; holds one
// transaction at a time, enforces the post-soft-reset settle time and a write timeout.
module sccb_write_arbiter
    import sccb_pkg::*;
#(
    parameter int         SETTLE_CYCLES   = 24000,
    parameter int         TIMEOUT_CYCLES  = 1000000,
    parameter logic [7:0] SOFT_RESET_ADDR = 8'h12
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_req0,
    input  logic       i_req1,
    input  logic [7:0] i_addr0,
    input  logic [7:0] i_addr1,
    input  logic [7:0] i_data0,
    input  logic [7:0] i_data1,
    output logic       o_ack0,
    output logic       o_ack1,
    output logic       o_timeout,
    output logic       o_wr_en,
    output logic [7:0] o_reg_addr,
    output logic [7:0] o_reg_data,
    input  logic       i_wr_done,
    output logic       o_busy,
    output logic       o_owner
);

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);

    sccb_state_e      state_r, state_nx_s;
    logic [CNT_W-1:0] cnt_r, cnt_nx_s;
    logic             owner_r, owner_nx_s;
    logic [7:0]       addr_r, addr_nx_s;
    logic [7:0]       data_r, data_nx_s;
    logic             ack0_r, ack0_nx_s;
    logic             ack1_r, ack1_nx_s;
    logic             timeout_r, timeout_nx_s;
    logic             wr_en_r, busy_r;
    logic             grant_s;

    // Round-robin: on contention the port that did not win last time goes next.
    assign grant_s = (i_req0 && i_req1) ? ~owner_r : i_req1;

    // Next-state, counter, grant latch and ack/timeout pulse generation.
    always_comb begin
        state_nx_s   = state_r;
        cnt_nx_s     = cnt_r;
        owner_nx_s   = owner_r;
        addr_nx_s    = addr_r;
        data_nx_s    = data_r;
        ack0_nx_s    = 1'b0;
        ack1_nx_s    = 1'b0;
        timeout_nx_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_nx_s = {CNT_W{1'b0}};
                if (i_req0 || i_req1) begin
                    owner_nx_s = grant_s;
                    addr_nx_s  = grant_s ? i_addr1 : i_addr0;
                    data_nx_s  = grant_s ? i_data1 : i_data0;
                    state_nx_s = ST_WRITE;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (i_wr_done) begin
                    ack0_nx_s  = ~owner_r;
                    ack1_nx_s  = owner_r;
                    cnt_nx_s   = {CNT_W{1'b0}};
                    state_nx_s = is_soft_reset_write(addr_r, data_r, SOFT_RESET_ADDR)
                                 ? ST_SETTLE : ST_IDLE;
                end else if (cnt_r == TIMEOUT_LAST) begin
                    ack0_nx_s    = ~owner_r;
                    ack1_nx_s    = owner_r;
                    timeout_nx_s = 1'b1;
                    cnt_nx_s     = {CNT_W{1'b0}};
                    state_nx_s   = ST_IDLE;
                end else begin
                    cnt_nx_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_SETTLE: begin
                if (cnt_r == SETTLE_LAST) begin
                    cnt_nx_s   = {CNT_W{1'b0}};
                    state_nx_s = ST_IDLE;
                end else begin
                    cnt_nx_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                cnt_nx_s   = {CNT_W{1'b0}};
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers; outputs follow the next state so they change on the same edge.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            owner_r   <= 1'b1;
            addr_r    <= 8'h00;
            data_r    <= 8'h00;
            ack0_r    <= 1'b0;
            ack1_r    <= 1'b0;
            timeout_r <= 1'b0;
            wr_en_r   <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            cnt_r     <= cnt_nx_s;
            owner_r   <= owner_nx_s;
            addr_r    <= addr_nx_s;
            data_r    <= data_nx_s;
            ack0_r    <= ack0_nx_s;
            ack1_r    <= ack1_nx_s;
            timeout_r <= timeout_nx_s;
            wr_en_r   <= (state_nx_s == ST_WRITE);
            busy_r    <= (state_nx_s != ST_IDLE);
        end
    end

    assign o_ack0     = ack0_r;
    assign o_ack1     = ack1_r;
    assign o_timeout  = timeout_r;
    assign o_wr_en    = wr_en_r;
    assign o_reg_addr = addr_r;
    assign o_reg_data = data_r;
    assign o_busy     = busy_r;
    assign o_owner    = owner_r;

endmodule

// File: tb/tb_sccb_write_arbiter.sv
// Directed bench for sccb_write_arbiter: transaction-level reference model checked
// every cycle, plus literal expectations on window lengths, gaps and grant order.
module tb_sccb_write_arbiter;

    localparam int SETTLE  = 20;
    localparam int TIMEOUT = 100;

    logic       clk = 1'b0;
    logic       rstn;
    logic       req0, req1;
    logic [7:0] addr0, addr1, data0, data1;
    logic       wr_done;
    logic       ack0, ack1, tmo, wr_en, busy, owner;
    logic [7:0] reg_addr, reg_data;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_on   = 1'b0;

    // model state: transaction in flight, its length, remaining settle cycles
    bit         m_active;
    int         m_len;
    int         m_hold;
    bit         m_owner, m_ack0, m_ack1, m_to;
    logic [7:0] m_addr, m_data;

    sccb_write_arbiter #(
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TIMEOUT),
        .SOFT_RESET_ADDR(8'h12)
    ) dut (
        .i_clk     (clk),
        .i_rstn    (rstn),
        .i_req0    (req0),
        .i_req1    (req1),
        .i_addr0   (addr0),
        .i_addr1   (addr1),
        .i_data0   (data0),
        .i_data1   (data1),
        .o_ack0    (ack0),
        .o_ack1    (ack1),
        .o_timeout (tmo),
        .o_wr_en   (wr_en),
        .o_reg_addr(reg_addr),
        .o_reg_data(reg_data),
        .i_wr_done (wr_done),
        .o_busy    (busy),
        .o_owner   (owner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: one write in flight, then optional settle hold, then grant.
    task automatic model_step();
        m_ack0 = 1'b0;
        m_ack1 = 1'b0;
        m_to   = 1'b0;
        if (!rstn) begin
            m_active = 1'b0; m_len = 0; m_hold = 0;
            m_owner = 1'b1; m_addr = 8'h00; m_data = 8'h00;
        end else if (m_active) begin
            m_len++;
            if (wr_done || m_len == TIMEOUT) begin
                if (m_owner) m_ack1 = 1'b1; else m_ack0 = 1'b1;
                m_to     = !wr_done;
                m_active = 1'b0;
                if (wr_done && m_addr == 8'h12 && m_data[7]) m_hold = SETTLE;
            end
        end else if (m_hold > 0) begin
            m_hold--;
        end else if (req0 || req1) begin
            if (req0 && req1) m_owner = !m_owner;
            else              m_owner = req1;
            m_addr   = m_owner ? addr1 : addr0;
            m_data   = m_owner ? data1 : data0;
            m_active = 1'b1;
            m_len    = 0;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Every-cycle comparison of all outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_on) begin
                chk("m_wr_en", {31'd0, wr_en}, {31'd0, m_active});
                chk("m_busy",  {31'd0, busy},  {31'd0, (m_active || m_hold > 0)});
                chk("m_ack0",  {31'd0, ack0},  {31'd0, m_ack0});
                chk("m_ack1",  {31'd0, ack1},  {31'd0, m_ack1});
                chk("m_tmo",   {31'd0, tmo},   {31'd0, m_to});
                chk("m_owner", {31'd0, owner}, {31'd0, m_owner});
                chk("m_addr",  {24'd0, reg_addr}, {24'd0, m_addr});
                chk("m_data",  {24'd0, reg_data}, {24'd0, m_data});
            end
        end
    end

    // Waits for a grant (counting low cycles), then acts as the engine: wr_done after lat
    // high cycles (0 = never). Returns at the ack cycle.
    task automatic txn(input int lat, output int gap, output int high,
                       output logic own, output logic [7:0] a, output logic [7:0] d);
        gap = 0;
        while (!wr_en && gap < 200) begin
            gap++;
            @(negedge clk);
        end
        if (!wr_en) chk("grant_wait", 32'd0, 32'd1);
        own = owner; a = reg_addr; d = reg_data;
        high = 0;
        while (wr_en && high < 500) begin
            high++;
            if (high == lat) wr_done = 1'b1;
            @(negedge clk);
            wr_done = 1'b0;
        end
        if (wr_en) chk("done_wait", 32'd1, 32'd0);
    endtask

    int         gap, high;
    logic       own;
    logic [7:0] a, d;

    initial begin
        rstn = 1'b0; req0 = 1'b0; req1 = 1'b0; wr_done = 1'b0;
        addr0 = 8'h00; addr1 = 8'h00; data0 = 8'h00; data1 = 8'h00;
        repeat (3) @(negedge clk);
        cmp_on = 1'b1;
        chk("rst_owner", {31'd0, owner}, 32'd1);
        chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("rst_busy",  {31'd0, busy},  32'd0);
        chk("rst_addr",  {24'd0, reg_addr}, 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // port 0 alone
        req0 = 1'b1; addr0 = 8'h3A; data0 = 8'h04;
        txn(80, gap, high, own, a, d);
        chk("p0_high",  high, 32'd80);
        chk("p0_owner", {31'd0, own}, 32'd0);
        chk("p0_addr",  {24'd0, a}, 32'h3A);
        chk("p0_data",  {24'd0, d}, 32'h04);
        chk("p0_ack0",  {31'd0, ack0}, 32'd1);
        chk("p0_ack1",  {31'd0, ack1}, 32'd0);
        req0 = 1'b0;
        repeat (3) @(negedge clk);

        // round robin from reset
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        req0 = 1'b1; req1 = 1'b1;
        addr0 = 8'h10; data0 = 8'h11; addr1 = 8'h20; data1 = 8'h21;
        txn(5, gap, high, own, a, d);
        chk("rr1_owner", {31'd0, own}, 32'd0);
        chk("rr1_addr",  {24'd0, a}, 32'h10);
        txn(5, gap, high, own, a, d);
        chk("rr2_owner", {31'd0, own}, 32'd1);
        chk("rr2_gap",   gap, 32'd1);
        chk("rr2_data",  {24'd0, d}, 32'h21);
        txn(5, gap, high, own, a, d);
        chk("rr3_owner", {31'd0, own}, 32'd0);
        chk("rr3_gap",   gap, 32'd1);
        req0 = 1'b0; req1 = 1'b0;
        repeat (3) @(negedge clk);

        // soft reset write from port 1 while port 0 waits
        req0 = 1'b1; addr0 = 8'h55; data0 = 8'h66;
        req1 = 1'b1; addr1 = 8'h12; data1 = 8'h80;
        txn(7, gap, high, own, a, d);
        chk("sr_owner", {31'd0, own}, 32'd1);
        chk("sr_ack1",  {31'd0, ack1}, 32'd1);
        req1 = 1'b0;
        txn(7, gap, high, own, a, d);
        chk("sr_gap",   gap, SETTLE + 1);
        chk("sr_next",  {31'd0, own}, 32'd0);
        chk("sr_addr",  {24'd0, a}, 32'h55);
        req0 = 1'b0;
        repeat (3) @(negedge clk);

        // timeout, then a normal write
        req1 = 1'b1; addr1 = 8'h30; data1 = 8'h31;
        txn(0, gap, high, own, a, d);
        chk("to_high", high, TIMEOUT);
        chk("to_ack1", {31'd0, ack1}, 32'd1);
        chk("to_flag", {31'd0, tmo}, 32'd1);
        req1 = 1'b0;
        @(negedge clk);
        req0 = 1'b1; addr0 = 8'h31; data0 = 8'h32;
        txn(4, gap, high, own, a, d);
        chk("after_to_high", high, 32'd4);
        chk("after_to_flag", {31'd0, tmo}, 32'd0);
        chk("after_to_ack0", {31'd0, ack0}, 32'd1);
        req0 = 1'b0;
        repeat (3) @(negedge clk);

        // reset mid-write, late done ignored
        req0 = 1'b1; addr0 = 8'h44; data0 = 8'h45;
        repeat (6) @(negedge clk);
        chk("mr_wr_en_pre", {31'd0, wr_en}, 32'd1);
        rstn = 1'b0; req0 = 1'b0;
        @(negedge clk);
        chk("mr_wr_en", {31'd0, wr_en}, 32'd0);
        chk("mr_busy",  {31'd0, busy},  32'd0);
        chk("mr_owner", {31'd0, owner}, 32'd1);
        chk("mr_ack0",  {31'd0, ack0},  32'd0);
        rstn = 1'b1; wr_done = 1'b1;
        @(negedge clk);
        wr_done = 1'b0;
        @(negedge clk);
        chk("late_ack0", {31'd0, ack0}, 32'd0);
        chk("late_busy", {31'd0, busy}, 32'd0);

        // stray done in IDLE, then a req1 glitch during a port-0 write
        wr_done = 1'b1;
        @(negedge clk);
        wr_done = 1'b0;
        @(negedge clk);
        chk("stray_ack0", {31'd0, ack0}, 32'd0);
        chk("stray_ack1", {31'd0, ack1}, 32'd0);
        req0 = 1'b1; addr0 = 8'h5A; data0 = 8'hA5;
        repeat (3) @(negedge clk);
        req1 = 1'b1; addr1 = 8'h77; data1 = 8'h88;
        @(negedge clk);
        req1 = 1'b0;
        @(negedge clk);
        chk("gl_addr",  {24'd0, reg_addr}, 32'h5A);
        chk("gl_data",  {24'd0, reg_data}, 32'hA5);
        chk("gl_owner", {31'd0, owner}, 32'd0);
        txn(5, gap, high, own, a, d);
        chk("gl_ack0", {31'd0, ack0}, 32'd1);
        chk("gl_ack1", {31'd0, ack1}, 32'd0);
        req0 = 1'b0;
        repeat (4) @(negedge clk);
        chk("gl_no_grant", {31'd0, wr_en}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
